// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly behind program_counter. Every cycle the
// incoming pc is offered to instruction memory; when the request cannot be
// issued (no credit, or memory does not grant), keep_pc tells the PC block to
// hold its value. In-order memory responses are paired with their fetch
// address and buffered in a small queue that feeds decode. A flush kills all
// queued and in-flight fetches; responses belonging to killed fetches are
// counted down and discarded as they come back.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (low = in reset)
//   pc           next fetch address from program_counter
//   keep_pc      1 = hold the PC, no fetch was issued this cycle
//   flush        redirect: discard everything issued before this cycle
//   imem_req     fetch request valid
//   imem_addr    fetch address (always equal to pc)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  response valid (in issue order, at least 1 cycle after grant)
//   imem_rdata   response instruction word
//   inst_valid   decode-side head entry valid
//   inst         instruction word at queue head
//   inst_pc      fetch address of inst
//   inst_ready   decode consumes the head when inst_valid is 1
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic        keep_pc,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    // Pointer width and counter width (counters span 0..DEPTH inclusive).
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0] live_reg,  live_next;   // outstanding, not killed
    logic [CW-1:0] drop_reg,  drop_next;   // outstanding, killed by flush
    logic [CW-1:0] count_reg, count_next;  // inst queue occupancy

    // Address FIFO: fetch addresses of live requests, oldest at a_rptr.
    logic [31:0]   addr_mem [DEPTH];
    logic [PW-1:0] a_wptr_reg, a_wptr_next;
    logic [PW-1:0] a_rptr_reg, a_rptr_next;

    // Instruction queue: {inst, pc} pairs for decode, head at q_rptr.
    logic [31:0]   q_inst_mem [DEPTH];
    logic [31:0]   q_pc_mem   [DEPTH];
    logic [PW-1:0] q_wptr_reg, q_wptr_next;
    logic [PW-1:0] q_rptr_reg, q_rptr_next;

    // Registered head outputs.
    logic [31:0]   head_inst_reg, head_inst_next;
    logic [31:0]   head_pc_reg,   head_pc_next;

    // ------------------------------------------------------------------
    // Issue side
    // ------------------------------------------------------------------
    logic [CW:0] used;      // credit consumed by live fetches and queued entries
    logic [CW:0] pending;   // every request memory still owes us a response for
    logic        credit_ok;
    logic        issue;

    assign used    = {1'b0, live_reg} + {1'b0, count_reg};
    assign pending = {1'b0, drop_reg} + {1'b0, live_reg};

    // Killed requests do not take queue credit, but the drop counter must not
    // overflow, so issue also stalls while live + drop has reached DEPTH.
    assign credit_ok = (used < DEPTH_W) && (pending < DEPTH_W);

    // Reset is folded in combinationally so the request drops the instant
    // reset is asserted, not at the next edge.
    assign imem_req  = reset & credit_ok;
    assign imem_addr = pc;
    assign issue     = imem_req & imem_gnt;
    assign keep_pc   = ~issue;

    // ------------------------------------------------------------------
    // Response / decode side
    // ------------------------------------------------------------------
    logic rsp_drop;   // response belongs to a killed fetch
    logic rsp_live;   // response belongs to a live fetch
    logic pop;
    logic a_we;
    logic [PW-1:0] a_waddr;
    logic q_we;

    // Killed fetches are always older than live ones, so they drain first.
    assign rsp_drop   = imem_rvalid && (drop_reg != '0);
    assign rsp_live   = imem_rvalid && (drop_reg == '0) && (live_reg != '0);
    assign inst_valid = (count_reg != '0);
    assign pop        = inst_valid & inst_ready;

    assign inst    = head_inst_reg;
    assign inst_pc = head_pc_reg;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [CW:0] killed;

    always_comb begin
        live_next      = live_reg;
        drop_next      = drop_reg;
        count_next     = count_reg;
        a_wptr_next    = a_wptr_reg;
        a_rptr_next    = a_rptr_reg;
        q_wptr_next    = q_wptr_reg;
        q_rptr_next    = q_rptr_reg;
        head_inst_next = head_inst_reg;
        head_pc_next   = head_pc_reg;
        a_we           = issue;
        a_waddr        = a_wptr_reg;
        q_we           = 1'b0;
        killed         = '0;

        if (flush) begin
            // Everything outstanding becomes killed; a response arriving in
            // this very cycle is one of them and is retired right away.
            killed = pending - {{CW{1'b0}}, (imem_rvalid && (pending != '0))};
            drop_next = (killed > DEPTH_W) ? DEPTH_C : killed[CW-1:0];

            // Both queues restart empty. The pc seen during the flush is the
            // redirect target, so a same-cycle issue lands in slot 0 as live.
            count_next  = '0;
            q_wptr_next = '0;
            q_rptr_next = '0;
            a_rptr_next = '0;
            a_waddr     = '0;
            a_wptr_next = issue ? PW'(1) : '0;
            live_next   = issue ? CW'(1) : '0;
        end else begin
            if (issue) begin
                a_wptr_next = a_wptr_reg + PW'(1);
            end

            if (rsp_drop) begin
                drop_next = drop_reg - CW'(1);
            end

            if (rsp_live) begin
                q_we        = 1'b1;
                a_rptr_next = a_rptr_reg + PW'(1);
                q_wptr_next = q_wptr_reg + PW'(1);
            end

            if (pop) begin
                q_rptr_next = q_rptr_reg + PW'(1);
            end

            live_next  = live_reg + CW'(issue) - CW'(rsp_live);
            count_next = count_reg + CW'(rsp_live) - CW'(pop);

            // Load the head register with whatever will sit at the head next
            // cycle. If that slot is the one being written right now (queue
            // empty after any pop), forward the incoming response instead.
            if (count_next != '0) begin
                if (q_we && (q_rptr_next == q_wptr_reg)) begin
                    head_inst_next = imem_rdata;
                    head_pc_next   = addr_mem[a_rptr_reg];
                end else begin
                    head_inst_next = q_inst_mem[q_rptr_next];
                    head_pc_next   = q_pc_mem[q_rptr_next];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_reg      <= '0;
            drop_reg      <= '0;
            count_reg     <= '0;
            a_wptr_reg    <= '0;
            a_rptr_reg    <= '0;
            q_wptr_reg    <= '0;
            q_rptr_reg    <= '0;
            head_inst_reg <= '0;
            head_pc_reg   <= '0;
        end else begin
            live_reg      <= live_next;
            drop_reg      <= drop_next;
            count_reg     <= count_next;
            a_wptr_reg    <= a_wptr_next;
            a_rptr_reg    <= a_rptr_next;
            q_wptr_reg    <= q_wptr_next;
            q_rptr_reg    <= q_rptr_next;
            head_inst_reg <= head_inst_next;
            head_pc_reg   <= head_pc_next;
        end
    end

    // Queue storage is cleared on reset so the head outputs never carry X.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]   <= '0;
                q_inst_mem[i] <= '0;
                q_pc_mem[i]   <= '0;
            end
        end else begin
            if (a_we) begin
                addr_mem[a_waddr] <= pc;
            end
            if (q_we) begin
                q_inst_mem[q_wptr_reg] <= imem_rdata;
                q_pc_mem[q_wptr_reg]   <= addr_mem[a_rptr_reg];
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch (DEPTH = 4). Inputs change 1 time unit
// after the rising edge and outputs are sampled 2-3 units after it. A simple
// fixed-latency-1 memory model lives in tick(); scenarios that need precise
// response timing drive imem_rvalid/imem_rdata by hand instead.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        keep_pc;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic        auto_mem;
    logic        pend;
    logic [31:0] paddr;

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .keep_pc    (keep_pc),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    // Memory content model: instruction word derived from its address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Advance one clock. With auto_mem set, a request granted this cycle is
    // answered in the next cycle (latency 1).
    task automatic tick();
        #1;
        pend  = reset && imem_req && imem_gnt;
        paddr = imem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_rvalid = pend;
            imem_rdata  = pend ? word_of(paddr) : 32'h0;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0; pc = 32'h0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0; auto_mem = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        n_checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h expected 0/0/0", inst_valid, inst, inst_pc);
        end
        n_checks++;
        if (imem_req !== 1'b0 || keep_pc !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_req: got req=%b keep=%b expected req=0 keep=1", imem_req, keep_pc);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || keep_pc !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_req: got req=%b keep=%b expected req=1 keep=1", imem_req, keep_pc);
        end
        $display("test_reset: done");
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream();
        imem_gnt = 1'b1; inst_ready = 1'b1; auto_mem = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = 32'(i * 4);
            #1;
            n_checks++;
            if (keep_pc !== 1'b0) begin
                n_errors++;
                $display("FAIL stream_keep_pc[%0d]: got %b expected 0", i, keep_pc);
            end
            n_checks++;
            if (i >= 2) begin
                if (inst_valid !== 1'b1 || inst_pc !== 32'((i - 2) * 4) || inst !== word_of(32'((i - 2) * 4))) begin
                    n_errors++;
                    $display("FAIL stream_head[%0d]: got valid=%b pc=%h inst=%h expected 1/%h/%h",
                             i, inst_valid, inst_pc, inst, 32'((i - 2) * 4), word_of(32'((i - 2) * 4)));
                end
            end else if (inst_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stream_head[%0d]: got valid=%b expected 0", i, inst_valid);
            end
            $display("stream cycle %0d: pc=%h keep_pc=%b inst_valid=%b inst_pc=%h", i, pc, keep_pc, inst_valid, inst_pc);
            tick();
        end
        imem_gnt = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_checks++;
            if (j < 2) begin
                if (inst_valid !== 1'b1 || inst_pc !== 32'((6 + j) * 4)) begin
                    n_errors++;
                    $display("FAIL stream_drain[%0d]: got valid=%b pc=%h expected 1/%h", j, inst_valid, inst_pc, 32'((6 + j) * 4));
                end
            end else if (inst_valid !== 1'b0 || dut.live_reg !== 3'd0) begin
                n_errors++;
                $display("FAIL stream_drain_empty: got valid=%b live=%0d expected 0/0", inst_valid, dut.live_reg);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure();
        logic exp_keep;
        imem_gnt = 1'b1; inst_ready = 1'b0; auto_mem = 1'b1;
        for (int c = 0; c < 6; c++) begin
            pc = 32'h200 + 32'(4 * ((c < 4) ? c : 4));
            #1;
            exp_keep = (c >= 4);
            n_checks++;
            if (keep_pc !== exp_keep || imem_req !== ~exp_keep) begin
                n_errors++;
                $display("FAIL bp_fill[%0d]: got keep=%b req=%b expected keep=%b", c, keep_pc, imem_req, exp_keep);
            end
            $display("backpressure cycle %0d: pc=%h keep_pc=%b imem_req=%b", c, pc, keep_pc, imem_req);
            tick();
        end
        #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || dut.count_reg !== 3'd4) begin
            n_errors++;
            $display("FAIL bp_full_head: got valid=%b pc=%h count=%0d expected 1/200/4", inst_valid, inst_pc, dut.count_reg);
        end
        // One pop: the credit it frees becomes usable the following cycle.
        inst_ready = 1'b1;
        n_checks++;
        if (imem_req !== 1'b0 || keep_pc !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_pop_cycle: got req=%b keep=%b expected 0/1", imem_req, keep_pc);
        end
        tick();
        inst_ready = 1'b0;
        #1;
        n_checks++;
        if (keep_pc !== 1'b0 || inst_pc !== 32'h204) begin
            n_errors++;
            $display("FAIL bp_one_issue: got keep=%b head_pc=%h expected 0/204", keep_pc, inst_pc);
        end
        tick();
        pc = 32'h214;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (imem_req !== 1'b0 || keep_pc !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_refull[%0d]: got req=%b keep=%b expected 0/1", c, imem_req, keep_pc);
            end
            tick();
        end
        inst_ready = 1'b1; imem_gnt = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            n_checks++;
            if (j < 4) begin
                if (inst_valid !== 1'b1 || inst_pc !== 32'h204 + 32'(4 * j)) begin
                    n_errors++;
                    $display("FAIL bp_drain[%0d]: got valid=%b pc=%h expected 1/%h", j, inst_valid, inst_pc, 32'h204 + 32'(4 * j));
                end
            end else if (inst_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_drain_empty: got valid=%b expected 0", inst_valid);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_grant_stall();
        imem_gnt = 1'b0; inst_ready = 1'b1; auto_mem = 1'b1; pc = 32'h300;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (keep_pc !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h300 || dut.live_reg !== 3'd0) begin
                n_errors++;
                $display("FAIL stall[%0d]: got keep=%b req=%b addr=%h live=%0d expected 1/1/300/0",
                         c, keep_pc, imem_req, imem_addr, dut.live_reg);
            end
            $display("grant stall cycle %0d: keep_pc=%b imem_addr=%h", c, keep_pc, imem_addr);
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        n_checks++;
        if (keep_pc !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_release: got keep=%b expected 0", keep_pc);
        end
        tick();
        imem_gnt = 1'b0; pc = 32'h304;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_latency: got valid=%b expected 0", inst_valid);
        end
        tick();
        #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h300 || inst !== word_of(32'h300)) begin
            n_errors++;
            $display("FAIL stall_entry: got valid=%b pc=%h inst=%h expected 1/300/%h", inst_valid, inst_pc, inst, word_of(32'h300));
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        auto_mem = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        inst_ready = 1'b0; imem_gnt = 1'b1;
        pc = 32'h400; tick();
        pc = 32'h404; tick();
        pc = 32'h408; tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = word_of(32'h400);
        #1;
        n_checks++;
        if (dut.live_reg !== 3'd3) begin
            n_errors++;
            $display("FAIL flush_setup_live: got %0d expected 3", dut.live_reg);
        end
        tick();
        // Flush cycle: one queued, two in flight, redirect to 0x100.
        imem_rvalid = 1'b0; flush = 1'b1; pc = 32'h100; imem_gnt = 1'b1;
        #1;
        n_checks++;
        if (inst_valid !== 1'b1 || keep_pc !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_cycle: got valid=%b keep=%b expected 1/0", inst_valid, keep_pc);
        end
        tick();
        flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || dut.drop_reg !== 3'd2 || dut.live_reg !== 3'd1) begin
            n_errors++;
            $display("FAIL flush_after: got valid=%b drop=%0d live=%0d expected 0/2/1", inst_valid, dut.drop_reg, dut.live_reg);
        end
        $display("flush: stale response 1 data=%h", imem_rdata);
        tick();
        imem_rdata = 32'hBAD0_0002;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || dut.drop_reg !== 3'd1) begin
            n_errors++;
            $display("FAIL flush_stale1: got valid=%b drop=%0d expected 0/1", inst_valid, dut.drop_reg);
        end
        $display("flush: stale response 2 data=%h", imem_rdata);
        tick();
        imem_rdata = word_of(32'h100);
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || dut.drop_reg !== 3'd0) begin
            n_errors++;
            $display("FAIL flush_stale2: got valid=%b drop=%0d expected 0/0", inst_valid, dut.drop_reg);
        end
        tick();
        imem_rvalid = 1'b0; inst_ready = 1'b1;
        #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== word_of(32'h100)) begin
            n_errors++;
            $display("FAIL flush_target: got valid=%b pc=%h inst=%h expected 1/100/%h", inst_valid, inst_pc, inst, word_of(32'h100));
        end
        tick();
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || dut.live_reg !== 3'd0) begin
            n_errors++;
            $display("FAIL flush_end: got valid=%b live=%0d expected 0/0", inst_valid, dut.live_reg);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush_rvalid();
        auto_mem = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b1; imem_gnt = 1'b1;
        pc = 32'h500; tick();
        flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = word_of(32'h500); pc = 32'h600;
        #1;
        n_checks++;
        if (keep_pc !== 1'b0) begin
            n_errors++;
            $display("FAIL flushrv_issue: got keep=%b expected 0", keep_pc);
        end
        tick();
        flush = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
        #1;
        n_checks++;
        if (dut.drop_reg !== 3'd0 || dut.live_reg !== 3'd1 || inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flushrv_state: got drop=%0d live=%0d valid=%b expected 0/1/0", dut.drop_reg, dut.live_reg, inst_valid);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = word_of(32'h600);
        #1;
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flushrv_no_entry: got valid=%b expected 0", inst_valid);
        end
        tick();
        imem_rvalid = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h600 || inst !== word_of(32'h600)) begin
            n_errors++;
            $display("FAIL flushrv_entry: got valid=%b pc=%h inst=%h expected 1/600/%h", inst_valid, inst_pc, inst, word_of(32'h600));
        end
        $display("flush+rvalid: first entry pc=%h", inst_pc);
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        auto_mem = 1'b1; imem_rvalid = 1'b0; inst_ready = 1'b0; imem_gnt = 1'b1;
        pc = 32'h700; tick();
        pc = 32'h704; tick();
        pc = 32'h708; tick();
        imem_gnt = 1'b0; tick();
        #1;
        n_checks++;
        if (inst_valid !== 1'b1 || dut.count_reg !== 3'd3 || inst_pc !== 32'h700) begin
            n_errors++;
            $display("FAIL areset_setup: got valid=%b count=%0d pc=%h expected 1/3/700", inst_valid, dut.count_reg, inst_pc);
        end
        // Assert reset mid-cycle, well away from any clock edge.
        reset = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b0 || keep_pc !== 1'b1 || inst_pc !== 32'h0 || dut.count_reg !== 3'd0) begin
            n_errors++;
            $display("FAIL areset_immediate: got valid=%b req=%b keep=%b pc=%h count=%0d expected 0/0/1/0/0",
                     inst_valid, imem_req, keep_pc, inst_pc, dut.count_reg);
        end
        $display("async reset: inst_valid=%b imem_req=%b", inst_valid, imem_req);
        tick();
        imem_gnt = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_errors++;
                $display("FAIL areset_hold[%0d]: got req=%b expected 0", c, imem_req);
            end
            tick();
        end
        reset = 1'b1; imem_gnt = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_release: got req=%b expected 1", imem_req);
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_grant_stall();
        test_flush();
        test_flush_rvalid();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #50000;
        $display("FAIL timeout: got no completion expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
